// File: rtl/beta_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : beta_pkg                                                    |
// | Brief  : Shared types and constants for the beta pipeline stages.    |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package beta_pkg;

  // Fetch-stage controller states
  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_REQ  = 2'd1,
    IF_WAIT = 2'd2
  } if_state_t;

  // addi x0, x0, 0 -- what decode sees before the first real fetch
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Uncompressed instructions only, so the PC always advances one word
  localparam int unsigned PC_STEP = 4;

endpackage : beta_pkg
`default_nettype wire

// File: rtl/beta_if_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : beta_if_stage                                               |
// | Brief  : Instruction fetch stage. Single-outstanding req/gnt/rvalid  |
// |          fetcher with redirect handling; responses that race a       |
// |          redirect are dropped.                                       |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module beta_if_stage
  import beta_pkg::*;
#(
  parameter int unsigned          DataWidth  = 32,
  parameter logic [DataWidth-1:0] BootAddr   = 32'h0000_0000,
  parameter bit                   Compressed = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 if_fetch_en_i,
  input  logic                 if_redirect_i,
  input  logic [DataWidth-1:0] if_redirect_pc_i,
  output logic                 if_imem_req_o,
  output logic [DataWidth-1:0] if_imem_addr_o,
  input  logic                 if_imem_gnt_i,
  input  logic                 if_imem_rvalid_i,
  input  logic [DataWidth-1:0] if_imem_rdata_i,
  output logic [DataWidth-1:0] if_instr_o,
  output logic                 if_new_instr_o,
  output logic [DataWidth-1:0] if_pc_o,
  output logic [DataWidth-1:0] if_next_pc_o,
  output logic                 if_stage_busy_o
);

  // Only the 32-bit, uncompressed configuration is implemented
  if (DataWidth != 32 || Compressed != 1'b0) begin : g_bad_cfg
    $error("beta_if_stage: only DataWidth=32 and Compressed=0 are supported");
  end

  localparam logic [DataWidth-1:0] STEP = DataWidth'(PC_STEP);

  if_state_t            state_q, state_d;
  logic [DataWidth-1:0] fetch_pc_q, fetch_pc_d;
  logic                 pend_q, pend_d;
  logic [DataWidth-1:0] pend_pc_q, pend_pc_d;
  logic [DataWidth-1:0] instr_q, instr_d;
  logic [DataWidth-1:0] pc_q, pc_d;
  logic [DataWidth-1:0] next_pc_q, next_pc_d;
  logic                 new_instr_q, new_instr_d;

  // Redirect targets are word aligned; the low two bits are dropped
  logic [DataWidth-1:0] redir_tgt;
  assign redir_tgt = if_redirect_pc_i & ~DataWidth'(3);

  assign if_imem_req_o   = (state_q == IF_REQ);
  assign if_imem_addr_o  = fetch_pc_q;
  assign if_stage_busy_o = (state_q != IF_IDLE);
  assign if_instr_o      = instr_q;
  assign if_new_instr_o  = new_instr_q;
  assign if_pc_o         = pc_q;
  assign if_next_pc_o    = next_pc_q;

  // Next-state logic for the fetch controller, PC and output registers
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    pend_d      = pend_q;
    pend_pc_d   = pend_pc_q;
    instr_d     = instr_q;
    pc_d        = pc_q;
    next_pc_d   = next_pc_q;
    new_instr_d = 1'b0;

    unique case (state_q)
      IF_IDLE: begin
        // Nothing in flight, so a redirect can retarget the PC directly
        if (if_redirect_i) fetch_pc_d = redir_tgt;
        if (if_fetch_en_i) state_d = IF_REQ;
      end
      IF_REQ: begin
        // The request must stay stable, so a redirect is only remembered
        if (if_redirect_i) begin
          pend_d    = 1'b1;
          pend_pc_d = redir_tgt;
        end
        if (if_imem_gnt_i) state_d = IF_WAIT;
      end
      IF_WAIT: begin
        if (if_imem_rvalid_i) begin
          state_d = IF_IDLE;
          if (pend_q || if_redirect_i) begin
            // Stale response: drop it and jump to the newest target
            fetch_pc_d = if_redirect_i ? redir_tgt : pend_pc_q;
            pend_d     = 1'b0;
          end else begin
            instr_d     = if_imem_rdata_i;
            pc_d        = fetch_pc_q;
            next_pc_d   = fetch_pc_q + STEP;
            new_instr_d = 1'b1;
            fetch_pc_d  = fetch_pc_q + STEP;
          end
        end else if (if_redirect_i) begin
          pend_d    = 1'b1;
          pend_pc_d = redir_tgt;
        end
      end
      default: state_d = IF_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IF_IDLE;
      fetch_pc_q  <= BootAddr;
      pend_q      <= 1'b0;
      pend_pc_q   <= BootAddr;
      instr_q     <= NOP_INSTR;
      pc_q        <= BootAddr;
      next_pc_q   <= BootAddr + STEP;
      new_instr_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      pend_q      <= pend_d;
      pend_pc_q   <= pend_pc_d;
      instr_q     <= instr_d;
      pc_q        <= pc_d;
      next_pc_q   <= next_pc_d;
      new_instr_q <= new_instr_d;
    end
  end

endmodule : beta_if_stage
`default_nettype wire

// File: doc/beta_if_stage.md
Name: beta_if_stage

Overview:
- Instruction fetch stage; first stage of the pipe, directly upstream of the decode stage.
- Generates the PC and runs a req/gnt/rvalid handshake to instruction memory, with one outstanding transaction.
- Registers each fetched word and presents it to decode with a one-cycle new-instruction pulse.
- Accepts control-flow redirects from execute; responses that are in flight when a redirect arrives are discarded.

Parameters:
- DataWidth, 32, width of PC, address and instruction lines; only 32 supported.
- BootAddr, 32'h0000_0000, PC loaded on reset.
- Compressed, 0, compressed-instruction support; only 0 supported, PC step fixed at 4.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; one clock; reset is synchronous and active-high.
- if_fetch_en_i  in  1  downstream ready; permits starting the next fetch.
- if_redirect_i  in  1  branch/jump taken (pulse).
- if_redirect_pc_i  in  DataWidth  redirect target.
- if_imem_req_o  out  1  memory request.
- if_imem_addr_o  out  DataWidth  request address.
- if_imem_gnt_i  in  1  request accepted.
- if_imem_rvalid_i  in  1  response valid.
- if_imem_rdata_i  in  DataWidth  response data.
- if_instr_o  out  DataWidth  registered instruction, to decode.
- if_new_instr_o  out  1  one-cycle pulse: if_instr_o is new.
- if_pc_o  out  DataWidth  address of if_instr_o.
- if_next_pc_o  out  DataWidth  if_pc_o + 4.
- if_stage_busy_o  out  1  a memory transaction is active.

Behaviour:
- Reset values:
  - state IDLE; fetch PC = BootAddr; pending-redirect flag 0.
  - if_imem_req_o 0; if_imem_addr_o = BootAddr.
  - if_instr_o 32'h0000_0013 (NOP); if_new_instr_o 0.
  - if_pc_o = BootAddr; if_next_pc_o = BootAddr + 4; if_stage_busy_o 0.
- Address rules:
  - if_imem_addr_o always equals the fetch-PC register.
  - Redirect targets have bits [1:0] forced to 0.
  - PC adds are 32-bit modulo (32'hFFFF_FFFC + 4 = 0).
- if_stage_busy_o = (state != IDLE).
- IDLE:
  - if_redirect_i: fetch PC <= target.
  - if_fetch_en_i: -> REQ. When both are set, REQ fetches the new target.
- REQ:
  - if_imem_req_o = 1; address held stable until grant.
  - if_imem_gnt_i: -> WAIT.
  - if_redirect_i: set pending flag and capture target. The request is never withdrawn or altered.
- WAIT:
  - if_imem_req_o = 0.
  - if_redirect_i without rvalid: set/overwrite pending flag and target; the latest redirect wins.
  - On if_imem_rvalid_i with pending flag set or if_redirect_i high:
    - discard data; no pulse;
    - fetch PC <= newest target (the same-cycle if_redirect_pc_i has priority over the stored one);
    - clear flag; -> IDLE.
  - On if_imem_rvalid_i with no redirect:
    - if_instr_o <= rdata; if_pc_o <= fetch PC; if_next_pc_o <= fetch PC + 4;
    - if_new_instr_o = 1 for exactly the following cycle;
    - fetch PC <= fetch PC + 4; -> IDLE.
- Minimum latency: if_fetch_en_i at cycle t -> req at t+1 -> gnt at t+1 -> rvalid at t+2 -> if_new_instr_o high at t+3.
- Waits on gnt and rvalid are unbounded; if_fetch_en_i is ignored outside IDLE.
- if_imem_rvalid_i outside WAIT and if_imem_gnt_i outside REQ are ignored.
- Reset mid-operation:
  - Returns to IDLE in the next cycle and drops any transaction.
  - Memory is reset by the same rst_i, so no stale response follows.
- Decode consumes if_instr_o combinationally. The register holds its value until the next accepted response.

Decomposition:
- Add to beta_pkg:
  - if_state_t enum (IDLE, REQ, WAIT);
  - NOP_INSTR = 32'h0000_0013;
  - PC_STEP = 4.
- Single module: the FSM, PC register, redirect-pending register and output registers.
- No sub-module warranted.

Test Plan:
- Reset, then if_fetch_en_i=1 held, memory gives gnt immediately and rvalid one cycle later with rdata 32'h0050_0093 -> req at addr 0x0; if_new_instr_o pulses once with if_instr_o=32'h0050_0093, if_pc_o=0x0, if_next_pc_o=0x4; next request at addr 0x4.
- Gnt delayed 3 cycles -> req and addr 0x4 stay stable all 3 cycles; busy=1 until rvalid; exactly one pulse.
- Redirect to 0x100 while in REQ; the response arrives 2 cycles later -> no pulse; next request at 0x100; if_instr_o keeps its previous value.
- Redirect to 0x200 in the same cycle as rvalid -> data discarded; next request at 0x200.
- Two redirects in WAIT (0x300, then 0x400) -> next request at 0x400.
- Redirect target 0x103 in IDLE with fetch_en -> request at 0x100.
- rst_i asserted during WAIT -> next cycle all outputs at reset values (if_instr_o=NOP, if_pc_o=BootAddr); a later rvalid in IDLE produces no pulse.
